jt10_adpcm_mux: RTL and testbench
=================================

Name: jt10_adpcm_mux

Overview:
- Time-multiplexed, parametrised ADPCM-A decoder for the YM2610-style ADPCM-A path.
- One shared two-stage registered datapath serves CH channels in round-robin order.
- Per-channel predictor value (x) and step size are held in internal register arrays.
- Outputs are tagged per-channel PCM samples and, optionally, a saturated per-round mix. Sits between the ADPCM nibble fetch logic and the sound mixer.

Parameters:
CH, 6, number of channels; legal range 2..16.
PCMW, 16, signed PCM output width.
STEPW, 15, step-size register width.
STEP_MIN, 127, lower step clamp and per-channel reset value.
STEP_MAX, 24576, upper step clamp; must be < 2^STEPW.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; one channel slot per cen cycle
data  in  4  ADPCM nibble for channel cur_ch; bit3 = sign
chon  in  1  channel cur_ch enabled
start  in  1  key-on: clear state of channel cur_ch
cur_ch  out  $clog2(CH)  channel whose data/chon/start are sampled this cen
pcm  out  PCMW  signed decoded sample
pcm_ch  out  $clog2(CH)  channel that pcm belongs to
pcm_valid  out  1  one-clk pulse when pcm/pcm_ch update
mix  out  PCMW  signed saturated sum of one round (optional feature)
mix_valid  out  1  one-clk pulse when mix updates (optional feature)

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state advances only on clk edges with cen=1.
- Reset values:
  - cur_ch=0, pcm=0, pcm_ch=0, pcm_valid=0, mix=0, mix_valid=0.
  - All x[k]=0 and step[k]=STEP_MIN.
  - Pipeline registers cleared, stage-B valid=0.
- Reset asserted mid-round aborts the round; no partial write-back occurs.
- Slot counter: cur_ch increments on each cen and wraps from CH-1 to 0.
- Stage A (cen with cur_ch=k):
  - Latch k, data, chon, start, x[k], step[k].
  - Compute d = ({data[2:0],1'b1} * step) >> 3, unsigned, STEPW+1 bits.
  - Factor by data[2:0]: 0-3 -> 57, 4 -> 77, 5 -> 102, 6 -> 128, 7 -> 153.
  - Compute sn = (step * factor) >> 6.
- Stage B (next cen):
  - xn = x + d, or x - d when data[3]=1, computed in PCMW+2 signed bits.
  - Saturate xn to [-2^(PCMW-1), 2^(PCMW-1)-1].
  - Clamp sn to [STEP_MIN, STEP_MAX].
  - If chon=0 or start=1, force xn=0 and sn=STEP_MIN; start takes priority and data is ignored.
  - Write x[k]=xn and step[k]=sn.
  - Set pcm=xn and pcm_ch=k; pulse pcm_valid for exactly one clk.
- Latency: 2 cen cycles from nibble sampling to pcm.
- Hazards: channel k is rewritten one cen after it is read and next read CH>=2 cens later, so no forwarding is needed.
- cen low: all registers hold and pcm_valid stays 0. pcm/pcm_ch hold their last values.
- Channels not in the current slot are never modified.

Optional Feature:
- Macro: JT10_ADPCM_MIX_EN.
- When defined:
  - Keep a signed accumulator of width PCMW+$clog2(CH).
  - The accumulator is reloaded with pcm of channel 0 and adds each later channel's pcm.
  - On the write-back of channel CH-1, mix = accumulator saturated to PCMW bits, and mix_valid pulses one clk.
  - The first round after reset produces mix_valid only once all CH channels have been written back.
- When undefined: mix is tied to 0, mix_valid is tied to 0, and no accumulator logic is built.

Test Plan:
1. Reset check: hold rst_n=0, then release -> pcm=0 and pcm_valid=0; first decode on any channel uses step=127.
2. Positive nibble: ch0 chon=1, data=4'b0000 -> pcm=15, pcm_ch=0 two cens later; step[0] clamps to 127 (raw 113).
3. Negative nibble: ch1 data=4'b1111 from reset -> pcm=-238, pcm_ch=1; next ch1 decode uses step=303.
4. Positive saturation: ch2 fed data=4'b0111 for 40 rounds -> step[2] sticks at 24576, pcm for ch2 sticks at 32767, no wrap to negative. Same test with 4'b1111 sticks at -32768.
5. Clear conditions: start=1 on ch2 mid-stream -> ch2 pcm=0 and step returns to 127. chon=0 on ch3 -> pcm=0. Other channels' values are unchanged bit-for-bit.
6. Mix (JT10_ADPCM_MIX_EN): all 6 channels saturated at 32767 -> mix=32767 with one mix_valid per 6 cens. Channels 0..5 at +100,-40,0,0,0,0 -> mix=60. Without the macro, mix=0 and mix_valid is never asserted.

Source files
------------

// File: rtl/jt10_adpcm_mux.sv
// jt10_adpcm_mux: time-multiplexed ADPCM-A decoder (YM2610 style).
// One shared two-stage datapath serves CH channels in round-robin order.
// Stage A latches the slot's nibble and state and forms the delta and the raw
// next step; stage B applies the delta, saturates and clamps, and writes the
// channel state back.
// Optional per-round mix output: define JT10_ADPCM_MIX_EN to build it.
module jt10_adpcm_mux #(
   parameter int CH       = 6,
   parameter int PCMW     = 16,
   parameter int STEPW    = 15,
   parameter int STEP_MIN = 127,
   parameter int STEP_MAX = 24576
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic [3:0]             data,
   input  logic                   chon,
   input  logic                   start,
   output logic [$clog2(CH)-1:0]  cur_ch,
   output logic signed [PCMW-1:0] pcm,
   output logic [$clog2(CH)-1:0]  pcm_ch,
   output logic                   pcm_valid,
   output logic signed [PCMW-1:0] mix,
   output logic                   mix_valid
);

   localparam int CHW = $clog2(CH);
   localparam int DW  = STEPW + 1;   // delta width
   localparam int SNW = STEPW + 2;   // unclamped next-step width
   localparam int XW  = PCMW + 2;    // predictor headroom for x +/- d
   localparam logic [CHW-1:0]   LAST_CH  = CHW'(CH - 1);
   localparam logic [STEPW-1:0] STEP_RST = STEPW'(STEP_MIN);

   // Saturate the widened predictor sum back to PCMW bits.
   function automatic logic signed [PCMW-1:0] sat_x(input logic signed [XW-1:0] v);
      logic [2:0] top;
      top = v[XW-1:PCMW-1];
      if (top == 3'b000 || top == 3'b111)
         sat_x = v[PCMW-1:0];
      else if (v[XW-1])
         sat_x = {1'b1, {(PCMW-1){1'b0}}};
      else
         sat_x = {1'b0, {(PCMW-1){1'b1}}};
   endfunction

   // Clamp the raw next step into [STEP_MIN, STEP_MAX].
   function automatic logic [STEPW-1:0] clamp_step(input logic [SNW-1:0] s);
      if (s < SNW'(STEP_MIN))
         clamp_step = STEPW'(STEP_MIN);
      else if (s > SNW'(STEP_MAX))
         clamp_step = STEPW'(STEP_MAX);
      else
         clamp_step = s[STEPW-1:0];
   endfunction

   // Step adaptation factor (scaled by 64) selected by nibble magnitude.
   function automatic logic [7:0] step_factor(input logic [2:0] m);
      case (m)
         3'd4:    step_factor = 8'd77;
         3'd5:    step_factor = 8'd102;
         3'd6:    step_factor = 8'd128;
         3'd7:    step_factor = 8'd153;
         default: step_factor = 8'd57;
      endcase
   endfunction

   // slot counter and per-channel state
   logic [CHW-1:0]         ch_q, ch_d;
   logic signed [PCMW-1:0] x_q    [CH];
   logic signed [PCMW-1:0] x_d    [CH];
   logic [STEPW-1:0]       step_q [CH];
   logic [STEPW-1:0]       step_d [CH];

   // stage A pipeline registers
   logic                   vld_p1_q, vld_p1_d;
   logic [CHW-1:0]         ch_p1_q, ch_p1_d;
   logic                   sign_p1_q, sign_p1_d;
   logic                   clr_p1_q, clr_p1_d;
   logic signed [PCMW-1:0] x_p1_q, x_p1_d;
   logic [DW-1:0]          d_p1_q, d_p1_d;
   logic [SNW-1:0]         sn_p1_q, sn_p1_d;

   // stage B output registers
   logic signed [PCMW-1:0] pcm_q, pcm_d;
   logic [CHW-1:0]         pcm_ch_q, pcm_ch_d;
   logic                   pcm_valid_q, pcm_valid_d;

   // combinational helpers
   logic [STEPW+3:0]       dprod;
   logic [STEPW+7:0]       sprod;
   logic signed [PCMW-1:0] x_a;
   logic [STEPW-1:0]       step_a;
   logic signed [XW-1:0]   xext, dext, xsum;
   logic signed [PCMW-1:0] xn;
   logic [STEPW-1:0]       sn;
   logic                   wb;

   // Stage A: advance the slot, read the slot's state, form delta and raw step.
   always_comb begin
      ch_d      = ch_q;
      vld_p1_d  = vld_p1_q;
      ch_p1_d   = ch_p1_q;
      sign_p1_d = sign_p1_q;
      clr_p1_d  = clr_p1_q;
      x_p1_d    = x_p1_q;
      d_p1_d    = d_p1_q;
      sn_p1_d   = sn_p1_q;
      x_a       = x_q[ch_q];
      step_a    = step_q[ch_q];
      dprod     = (STEPW+4)'({data[2:0], 1'b1}) * (STEPW+4)'(step_a);
      sprod     = (STEPW+8)'(step_factor(data[2:0])) * (STEPW+8)'(step_a);
      if (cen) begin
         ch_d      = (ch_q == LAST_CH) ? '0 : ch_q + CHW'(1);
         vld_p1_d  = 1'b1;
         ch_p1_d   = ch_q;
         sign_p1_d = data[3];
         // key-on wins over everything; a disabled channel is also held at rest
         clr_p1_d  = start || !chon;
         x_p1_d    = x_a;
         d_p1_d    = DW'(dprod >> 3);
         sn_p1_d   = SNW'(sprod >> 6);
      end
   end

   // Stage B: apply delta, saturate/clamp, write back and present the sample.
   always_comb begin
      xext = {{2{x_p1_q[PCMW-1]}}, x_p1_q};
      dext = XW'(d_p1_q);
      xsum = sign_p1_q ? (xext - dext) : (xext + dext);
      xn   = sat_x(xsum);
      sn   = clamp_step(sn_p1_q);
      if (clr_p1_q) begin
         xn = '0;
         sn = STEP_RST;
      end
      wb          = cen && vld_p1_q;
      x_d         = x_q;
      step_d      = step_q;
      pcm_d       = pcm_q;
      pcm_ch_d    = pcm_ch_q;
      pcm_valid_d = 1'b0;
      if (wb) begin
         // channel ch_p1_q is not read again for at least CH-1 slots
         x_d[ch_p1_q]    = xn;
         step_d[ch_p1_q] = sn;
         pcm_d           = xn;
         pcm_ch_d        = ch_p1_q;
         pcm_valid_d     = 1'b1;
      end
   end

   // State, pipeline and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q        <= '0;
         vld_p1_q    <= 1'b0;
         ch_p1_q     <= '0;
         sign_p1_q   <= 1'b0;
         clr_p1_q    <= 1'b0;
         x_p1_q      <= '0;
         d_p1_q      <= '0;
         sn_p1_q     <= '0;
         pcm_q       <= '0;
         pcm_ch_q    <= '0;
         pcm_valid_q <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            x_q[k]    <= '0;
            step_q[k] <= STEP_RST;
         end
      end else begin
         ch_q        <= ch_d;
         vld_p1_q    <= vld_p1_d;
         ch_p1_q     <= ch_p1_d;
         sign_p1_q   <= sign_p1_d;
         clr_p1_q    <= clr_p1_d;
         x_p1_q      <= x_p1_d;
         d_p1_q      <= d_p1_d;
         sn_p1_q     <= sn_p1_d;
         pcm_q       <= pcm_d;
         pcm_ch_q    <= pcm_ch_d;
         pcm_valid_q <= pcm_valid_d;
         x_q         <= x_d;
         step_q      <= step_d;
      end
   end

   assign cur_ch    = ch_q;
   assign pcm       = pcm_q;
   assign pcm_ch    = pcm_ch_q;
   assign pcm_valid = pcm_valid_q;

`ifdef JT10_ADPCM_MIX_EN
   localparam int ACCW = PCMW + CHW;

   // Saturate the round accumulator to PCMW bits.
   function automatic logic signed [PCMW-1:0] sat_mix(input logic signed [ACCW-1:0] v);
      if ((&v[ACCW-1:PCMW-1]) || !(|v[ACCW-1:PCMW-1]))
         sat_mix = v[PCMW-1:0];
      else if (v[ACCW-1])
         sat_mix = {1'b1, {(PCMW-1){1'b0}}};
      else
         sat_mix = {1'b0, {(PCMW-1){1'b1}}};
   endfunction

   logic signed [ACCW-1:0] acc_q, acc_d, xn_ext;
   logic                   acc_ok_q, acc_ok_d;
   logic signed [PCMW-1:0] mix_q, mix_d;
   logic                   mix_valid_q, mix_valid_d;

   // Round accumulator: restart on channel 0, publish after channel CH-1.
   always_comb begin
      xn_ext      = {{CHW{xn[PCMW-1]}}, xn};
      acc_d       = acc_q;
      acc_ok_d    = acc_ok_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      if (wb) begin
         if (ch_p1_q == '0) begin
            acc_d    = xn_ext;
            acc_ok_d = 1'b1;
         end else begin
            acc_d = acc_q + xn_ext;
         end
         // acc_ok_q guards against publishing a round that started before reset
         if (ch_p1_q == LAST_CH && acc_ok_q) begin
            mix_d       = sat_mix(acc_d);
            mix_valid_d = 1'b1;
         end
      end
   end

   // Mix registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         acc_ok_q    <= 1'b0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_ok_q    <= acc_ok_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
      end
   end

   assign mix       = mix_q;
   assign mix_valid = mix_valid_q;
`else
   assign mix       = '0;
   assign mix_valid = 1'b0;
`endif

endmodule

// File: tb/tb_jt10_adpcm_mux.sv
// tb_jt10_adpcm_mux: directed stimulus with an arithmetic reference model of
// the decoder and a per-cycle comparison of every output.
module tb_jt10_adpcm_mux;

   localparam int CH   = 6;
   localparam int SMIN = 127;
   localparam int SMAX = 24576;
   localparam int PMAX = 32767;
   localparam int PMIN = -32768;

   logic               clk = 1'b0;
   logic               rst_n, cen, chon, start;
   logic [3:0]         data;
   logic [2:0]         cur_ch, pcm_ch;
   logic signed [15:0] pcm, mix;
   logic               pcm_valid, mix_valid;

   jt10_adpcm_mux #(.CH(CH), .PCMW(16), .STEPW(15), .STEP_MIN(SMIN), .STEP_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .data(data), .chon(chon), .start(start),
      .cur_ch(cur_ch), .pcm(pcm), .pcm_ch(pcm_ch), .pcm_valid(pcm_valid),
      .mix(mix), .mix_valid(mix_valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   int mx[CH];
   int mst[CH];
   int m_slot;
   bit p_v;
   int p_ch, p_val;
   bit e_valid;
   int e_ch, e_pcm;
   int macc;
   bit mseen;
   bit e_mv;
   int e_mix;

   function automatic int clip(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int decode(input int k, input logic [3:0] dt, input logic on, input logic st);
      int m, d, x, f, s;
      m = int'(dt[2:0]);
      d = ((2 * m + 1) * mst[k]) / 8;
      x = dt[3] ? mx[k] - d : mx[k] + d;
      x = clip(x, PMIN, PMAX);
      case (m)
         4: f = 77;
         5: f = 102;
         6: f = 128;
         7: f = 153;
         default: f = 57;
      endcase
      s = clip((mst[k] * f) / 64, SMIN, SMAX);
      if (!on || st) begin
         x = 0;
         s = SMIN;
      end
      mx[k]  = x;
      mst[k] = s;
      return x;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int k = 0; k < CH; k++) begin
               mx[k]  = 0;
               mst[k] = SMIN;
            end
            m_slot = 0; p_v = 0; p_ch = 0; p_val = 0;
            e_valid = 0; e_ch = 0; e_pcm = 0;
            macc = 0; mseen = 0; e_mv = 0; e_mix = 0;
         end else begin
            e_mv = 0;
            if (cen) begin
               e_valid = p_v;
               if (p_v) begin
                  e_ch  = p_ch;
                  e_pcm = p_val;
                  if (p_ch == 0) begin
                     macc  = p_val;
                     mseen = 1;
                  end else begin
                     macc += p_val;
                  end
                  if (p_ch == CH - 1 && mseen) begin
                     e_mix = clip(macc, PMIN, PMAX);
                     e_mv  = 1;
                  end
               end
               p_val  = decode(m_slot, data, chon, start);
               p_ch   = m_slot;
               p_v    = 1;
               m_slot = (m_slot + 1) % CH;
            end else begin
               e_valid = 0;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   initial begin
      forever begin
         @(negedge clk);
         check("cur_ch", int'(cur_ch), m_slot);
         check("pcm_valid", int'(pcm_valid), int'(e_valid));
         check("pcm", int'(pcm), e_pcm);
         check("pcm_ch", int'(pcm_ch), e_ch);
`ifdef JT10_ADPCM_MIX_EN
         check("mix", int'(mix), e_mix);
         check("mix_valid", int'(mix_valid), int'(e_mv));
`else
         check("mix_off", int'(mix), 0);
         check("mix_valid_off", int'(mix_valid), 0);
`endif
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] s_data[CH];
   bit         s_chon[CH];
   bit         s_start[CH];
   bit         gaps = 0;

   // drive the inputs for the next sampled slot, then move to the next negedge
   task automatic cyc();
      cen   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data  = s_data[m_slot];
      chon  = s_chon[m_slot];
      start = s_start[m_slot];
      @(negedge clk);
   endtask

   task automatic run_cens(input int n);
      int c = 0;
      while (c < n) begin
         cyc();
         if (cen) c++;
      end
   endtask

   task automatic align();
      int g = 0;
      while (m_slot != 0 && g < 100) begin
         cyc();
         g++;
      end
      check("align", m_slot, 0);
   endtask

   task automatic wait_pcm(input int ch, input string nm, output bit ok);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!(pcm_valid && int'(pcm_ch) == ch) && n < 200);
      ok = pcm_valid && int'(pcm_ch) == ch;
      if (!ok) check({nm, "_timeout"}, 0, 1);
   endtask

   task automatic expect_pcm(input int ch, input string nm, input int lit);
      bit ok;
      wait_pcm(ch, nm, ok);
      if (ok) begin
         check(nm, int'(pcm), lit);
         check({nm, "_model"}, e_pcm, lit);
      end
   endtask

`ifdef JT10_ADPCM_MIX_EN
   task automatic expect_mix(input string nm, input int lit);
      int n = 0;
      do begin
         cyc();
         n++;
      end while (!mix_valid && n < 200);
      if (!mix_valid) check({nm, "_timeout"}, 0, 1);
      else begin
         check(nm, int'(mix), lit);
         check({nm, "_model"}, e_mix, lit);
      end
   endtask
`endif

   initial begin
      bit ok;
      rst_n = 1'b0; cen = 1'b0; data = 4'd0; chon = 1'b0; start = 1'b0;
      for (int k = 0; k < CH; k++) begin
         s_data[k] = 4'd0; s_chon[k] = 0; s_start[k] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_pcm", int'(pcm), 0);
      check("rst_pcm_valid", int'(pcm_valid), 0);
      check("rst_cur_ch", int'(cur_ch), 0);

      // first decodes from reset: positive and negative nibbles at step 127
      s_chon[0] = 1; s_data[0] = 4'b0000;
      s_chon[1] = 1; s_data[1] = 4'b1111;
      rst_n = 1'b1;
      expect_pcm(0, "pos_nibble", 15);
      expect_pcm(1, "neg_nibble", -238);
      expect_pcm(0, "pos_again", 30);
      expect_pcm(1, "neg_step303", -806);

      // saturation on ch2 with irregular cen
      gaps = 1;
      s_chon[2] = 1; s_data[2] = 4'b0111;
      run_cens(40 * CH);
      expect_pcm(2, "sat_pos", PMAX);
      check("sat_step_model", mst[2], SMAX);
      s_data[2] = 4'b1111;
      run_cens(40 * CH);
      expect_pcm(2, "sat_neg", PMIN);

      // key-on and channel-off clearing
      gaps = 0;
      s_chon[3] = 1; s_data[3] = 4'b0001;
      run_cens(3 * CH);
      align();
      s_start[2] = 1; s_data[2] = 4'b0111;
      run_cens(3);
      expect_pcm(2, "start_clr", 0);
      s_start[2] = 0;
      s_chon[3]  = 0;
      wait_pcm(3, "ch3_last_on", ok);
      expect_pcm(2, "restart_step127", 238);
      expect_pcm(3, "chon_off", 0);

      // reset in the middle of a round
      gaps = 1;
      run_cens(4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_pcm", int'(pcm), 0);
      check("midrst_cur_ch", int'(cur_ch), 0);
      expect_pcm(0, "post_rst", 15);

      // all channels driven to saturation, then a small hand-checked round
      for (int k = 0; k < CH; k++) begin
         s_chon[k] = 1; s_data[k] = 4'b0111; s_start[k] = 0;
      end
      run_cens(40 * CH);
`ifdef JT10_ADPCM_MIX_EN
      expect_mix("mix_pos_sat", PMAX);
`endif
      for (int k = 0; k < CH; k++) s_data[k] = 4'b1111;
      run_cens(40 * CH);
`ifdef JT10_ADPCM_MIX_EN
      expect_mix("mix_neg_sat", PMIN);
`endif
      gaps = 0;
      align();
      for (int k = 0; k < CH; k++) s_start[k] = 1;
      run_cens(CH);
      for (int k = 0; k < CH; k++) begin
         s_start[k] = 0; s_chon[k] = (k < 2);
      end
      s_data[0] = 4'b0011; s_data[1] = 4'b1000;
      run_cens(CH);
      s_data[0] = 4'b1000;
`ifdef JT10_ADPCM_MIX_EN
      expect_mix("mix_round_b", 96);
      expect_mix("mix_round_c", 66);
`else
      run_cens(2 * CH);
`endif
      repeat (4) cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
